mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory port.
// Port 0 is the CPU data port and port 1 is the debug/DMA port. Each access is
// granted, held on the memory side until mem_ack or a wait timeout, and then
// completed with a one-cycle done pulse. err marks a timed-out access.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   m<i>_req/we/addr/wdata      requester i access request and payload
//   m<i>_gnt/done/err/rdata     requester i grant pulse, completion, timeout
//                               flag and held read data
//   mem_req/we/addr/wdata       memory access strobe and payload
//   mem_ack, mem_rdata          memory completion and read data
//   busy                        high while a transaction is in flight
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Wait counter wide enough for the largest legal TIMEOUT (255).
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_idx;
    logic          r_last;
    logic          r_busy;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [1:0]    r_gnt;
    logic [1:0]    r_done;
    logic [1:0]    r_err;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic [CW-1:0] r_wait;
    logic          w_win;

    // Winner: the lone requester, or on a tie the port not granted last.
    assign w_win = (m0_req && m1_req) ? ~r_last : m1_req;

    // Arbitration and transaction FSM; the mem_* registers double as the
    // latched request and are cleared whenever mem_req drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 1'b0;
            r_last      <= 1'b1;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_wait      <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_state      <= ST_ACCESS;
                        r_busy       <= 1'b1;
                        r_idx        <= w_win;
                        r_last       <= w_win;
                        r_gnt[w_win] <= 1'b1;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= w_win ? m1_we    : m0_we;
                        r_mem_addr   <= w_win ? m1_addr  : m0_addr;
                        r_mem_wdata  <= w_win ? m1_wdata : m0_wdata;
                        r_wait       <= '0;
                    end
                end
                ST_ACCESS: begin
                    // Ack wins over a timeout expiring in the same cycle.
                    if (mem_ack) begin
                        r_state       <= ST_RESP;
                        r_done[r_idx] <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_mem_addr    <= '0;
                        r_mem_wdata   <= '0;
                        if (!r_mem_we) begin
                            if (r_idx) begin
                                r_m1_rdata <= mem_rdata;
                            end else begin
                                r_m0_rdata <= mem_rdata;
                            end
                        end
                    end else if (r_wait == CW'(TIMEOUT - 1)) begin
                        r_state       <= ST_RESP;
                        r_done[r_idx] <= 1'b1;
                        r_err[r_idx]  <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_mem_addr    <= '0;
                        r_mem_wdata   <= '0;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_done   = r_done[0];
    assign m1_done   = r_done[1];
    assign m0_err    = r_err[0];
    assign m1_err    = r_err[1];
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule
